// File: rtl/iob_ram_tdp_be_pipe.sv
// True dual-port RAM with byte write enables, selectable same-port read-during-write
// behaviour, optional output register, read-valid strobes and cross-port collision flag.
module iob_ram_tdp_be_pipe #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int MODE    = 0,
    parameter int OUT_REG = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enA_i,
    input  logic [DATA_W/8-1:0] weA_i,
    input  logic [ADDR_W-1:0]   addrA_i,
    input  logic [DATA_W-1:0]   dA_i,
    output logic [DATA_W-1:0]   dA_o,
    output logic                dA_valid_o,
    input  logic                enB_i,
    input  logic [DATA_W/8-1:0] weB_i,
    input  logic [ADDR_W-1:0]   addrB_i,
    input  logic [DATA_W-1:0]   dB_i,
    output logic [DATA_W-1:0]   dB_o,
    output logic                dB_valid_o,
    output logic                collision_o
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        READ_FIRST  = 2'd0,
        WRITE_FIRST = 2'd1,
        NO_CHANGE   = 2'd2
    } rdw_mode_t;

    localparam rdw_mode_t RDW = rdw_mode_t'(MODE[1:0]);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] nxt_a, nxt_b;
    logic              upd_a, upd_b;
    logic [DATA_W-1:0] rd_a, rd_b;
    logic              rv_a, rv_b;
    logic              coll_q;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                input logic [DATA_W-1:0] d,
                                                input logic [NB-1:0]     we);
        logic [DATA_W-1:0] r;
        r = old;
        for (int unsigned k = 0; k < NB; k++) begin
            if (we[k]) r[8*k +: 8] = d[8*k +: 8];
        end
        return r;
    endfunction

    // Port A's assignment comes last, so it wins any lane both ports write at the same address.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (enB_i && weB_i[k]) mem[addrB_i][8*k +: 8] <= dB_i[8*k +: 8];
                if (enA_i && weA_i[k]) mem[addrA_i][8*k +: 8] <= dA_i[8*k +: 8];
            end
        end
    end

    always_comb begin
        nxt_a = mem[addrA_i];
        upd_a = enA_i;
        nxt_b = mem[addrB_i];
        upd_b = enB_i;
        case (RDW)
            WRITE_FIRST: begin
                nxt_a = merge(mem[addrA_i], dA_i, weA_i);
                nxt_b = merge(mem[addrB_i], dB_i, weB_i);
            end
            NO_CHANGE: begin
                if (|weA_i) upd_a = 1'b0;
                if (|weB_i) upd_b = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_a   <= '0;
            rd_b   <= '0;
            rv_a   <= 1'b0;
            rv_b   <= 1'b0;
            coll_q <= 1'b0;
        end else begin
            rv_a <= upd_a;
            rv_b <= upd_b;
            if (upd_a) rd_a <= nxt_a;
            if (upd_b) rd_b <= nxt_b;
            coll_q <= enA_i && enB_i && (addrA_i == addrB_i) && (|weA_i || |weB_i);
        end
    end

    assign collision_o = coll_q;

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_W-1:0] q_a, q_b;
            logic              v_a, v_b;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    q_a <= '0;
                    q_b <= '0;
                    v_a <= 1'b0;
                    v_b <= 1'b0;
                end else begin
                    v_a <= rv_a;
                    v_b <= rv_b;
                    if (rv_a) q_a <= rd_a;
                    if (rv_b) q_b <= rd_b;
                end
            end

            assign dA_o       = q_a;
            assign dA_valid_o = v_a;
            assign dB_o       = q_b;
            assign dB_valid_o = v_b;
        end else begin : g_noreg
            assign dA_o       = rd_a;
            assign dA_valid_o = rv_a;
            assign dB_o       = rd_b;
            assign dB_valid_o = rv_b;
        end
    endgenerate

endmodule

// File: tb/tb_iob_ram_tdp_be_pipe.sv
// Scoreboard bench for iob_ram_tdp_be_pipe: all six MODE/OUT_REG combinations share one
// stimulus stream; each instance has its own reference model and expected-read queues.
module tb_iob_ram_tdp_be_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enA = 1'b0, enB = 1'b0;
    logic [3:0]  weA = '0, weB = '0;
    logic [3:0]  addrA = '0, addrB = '0;
    logic [31:0] dA = '0, dB = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;
    bit mon_on = 1'b0;

    typedef struct {
        logic [31:0] data;
        bit          known;
        int          due;
    } exp_t;

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge32(input logic [31:0] old, input logic [31:0] d,
                                            input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (we[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    for (genvar g = 0; g < 6; g++) begin : g_cfg
        localparam int M = g % 3;
        localparam int R = g / 3;

        logic [31:0] da, db;
        logic        va, vb, coll;

        iob_ram_tdp_be_pipe #(
            .DATA_W (32),
            .ADDR_W (4),
            .MODE   (M),
            .OUT_REG(R)
        ) u_dut (
            .clk_i      (clk),
            .rst_i      (rst),
            .enA_i      (enA),
            .weA_i      (weA),
            .addrA_i    (addrA),
            .dA_i       (dA),
            .dA_o       (da),
            .dA_valid_o (va),
            .enB_i      (enB),
            .weB_i      (weB),
            .addrB_i    (addrB),
            .dB_i       (dB),
            .dB_o       (db),
            .dB_valid_o (vb),
            .collision_o(coll)
        );

        logic [31:0] ref_mem [16];
        logic [15:0] written = '0;
        exp_t        qa[$], qb[$];
        logic [31:0] hold_a = '0, hold_b = '0;
        bit          hk_a = 1'b0, hk_b = 1'b0;
        logic        exp_coll = 1'b0;

        // Reference model: reads see pre-edge contents, then writes apply with port A owning shared lanes.
        always @(posedge clk) begin
            exp_t e;
            if (rst) begin
                qa.delete();
                qb.delete();
                hold_a = '0; hk_a = 1'b1;
                hold_b = '0; hk_b = 1'b1;
                exp_coll = 1'b0;
            end else begin
                exp_coll = enA && enB && (addrA == addrB) && (|weA || |weB);
                if (enA && !(M == 2 && |weA)) begin
                    e.data  = (M == 1) ? merge32(ref_mem[addrA], dA, weA) : ref_mem[addrA];
                    e.known = written[addrA] || (M == 1 && weA == 4'hF);
                    e.due   = edge_n + 1 + R;
                    qa.push_back(e);
                end
                if (enB && !(M == 2 && |weB)) begin
                    e.data  = (M == 1) ? merge32(ref_mem[addrB], dB, weB) : ref_mem[addrB];
                    e.known = written[addrB] || (M == 1 && weB == 4'hF);
                    e.due   = edge_n + 1 + R;
                    qb.push_back(e);
                end
                for (int k = 0; k < 4; k++) begin
                    if (enB && weB[k] && !(enA && weA[k] && addrA == addrB))
                        ref_mem[addrB][8*k +: 8] = dB[8*k +: 8];
                    if (enA && weA[k])
                        ref_mem[addrA][8*k +: 8] = dA[8*k +: 8];
                end
                if (enB && weB == 4'hF) written[addrB] = 1'b1;
                if (enA && weA == 4'hF) written[addrA] = 1'b1;
            end
        end

        always @(negedge clk) begin
            exp_t e;
            if (mon_on) begin
                if (va) begin
                    if (qa.size() == 0) begin
                        check_eq($sformatf("c%0d_A_spurious_valid", g), 32'(va), 32'd0);
                    end else begin
                        e = qa.pop_front();
                        if (e.known) check_eq($sformatf("c%0d_A_data", g), da, e.data);
                        check_eq($sformatf("c%0d_A_latency", g), 32'(edge_n), 32'(e.due));
                        hold_a = e.data; hk_a = e.known;
                    end
                end else begin
                    if (qa.size() > 0 && qa[0].due <= edge_n) begin
                        e = qa.pop_front();
                        check_eq($sformatf("c%0d_A_missing_valid", g), 32'(va), 32'd1);
                    end
                    if (hk_a) check_eq($sformatf("c%0d_A_hold", g), da, hold_a);
                end
                if (vb) begin
                    if (qb.size() == 0) begin
                        check_eq($sformatf("c%0d_B_spurious_valid", g), 32'(vb), 32'd0);
                    end else begin
                        e = qb.pop_front();
                        if (e.known) check_eq($sformatf("c%0d_B_data", g), db, e.data);
                        check_eq($sformatf("c%0d_B_latency", g), 32'(edge_n), 32'(e.due));
                        hold_b = e.data; hk_b = e.known;
                    end
                end else begin
                    if (qb.size() > 0 && qb[0].due <= edge_n) begin
                        e = qb.pop_front();
                        check_eq($sformatf("c%0d_B_missing_valid", g), 32'(vb), 32'd1);
                    end
                    if (hk_b) check_eq($sformatf("c%0d_B_hold", g), db, hold_b);
                end
                check_eq($sformatf("c%0d_collision", g), 32'(coll), 32'(exp_coll));
            end
        end
    end

    task automatic drive(input logic ea, input logic [3:0] wa, input logic [3:0] aa,
                         input logic [31:0] xa, input logic eb, input logic [3:0] wb,
                         input logic [3:0] ab, input logic [31:0] xb);
        enA = ea; weA = wa; addrA = aa; dA = xa;
        enB = eb; weB = wb; addrB = ab; dB = xb;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        mon_on = 1'b1;
        idle(1);
        rst = 1'b0;

        // Fill: A writes 32+i everywhere, then B reads back every address.
        for (int i = 0; i < 16; i++) drive(1'b1, 4'hF, 4'(i), 32'(32 + i), 1'b0, 4'h0, 4'h0, 32'h0);
        for (int i = 0; i < 16; i++) drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0, 4'(i), 32'h0);
        idle(2);

        // Byte-enable merge on addr 3.
        drive(1'b1, 4'hF, 4'd3, 32'h1122_3344, 1'b0, 4'h0, 4'h0, 32'h0);
        drive(1'b1, 4'b0101, 4'd3, 32'hAABB_CCDD, 1'b0, 4'h0, 4'h0, 32'h0);
        drive(1'b1, 4'h0, 4'd3, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
        idle(2);

        // Same-port read-during-write on addr 5, then readback.
        drive(1'b1, 4'hF, 4'd5, 32'h55, 1'b0, 4'h0, 4'h0, 32'h0);
        idle(2);
        drive(1'b1, 4'h0, 4'd5, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
        idle(2);

        // Write/write collision on addr 7; A owns the overlapping lanes.
        drive(1'b1, 4'hF, 4'd7, 32'hFFFF_FFFF, 1'b1, 4'h3, 4'd7, 32'h0);
        idle(1);
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0, 4'd7, 32'h0);
        idle(2);

        // A writes addr 9 while B reads it; then B reads again, then both read (no collision).
        drive(1'b1, 4'hF, 4'd9, 32'h99, 1'b1, 4'h0, 4'd9, 32'h0);
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0, 4'd9, 32'h0);
        drive(1'b1, 4'h0, 4'd9, 32'h0, 1'b1, 4'h0, 4'd9, 32'h0);
        idle(2);

        // Disjoint lanes from both ports on addr 10.
        drive(1'b1, 4'b0011, 4'd10, 32'h0000_AAAA, 1'b1, 4'b1100, 4'd10, 32'hBBBB_0000);
        drive(1'b1, 4'h0, 4'd10, 32'h0, 1'b1, 4'h0, 4'd10, 32'h0);
        idle(2);

        // Back-to-back reads with a two-cycle reset burst; a write during reset must be ignored.
        for (int i = 0; i < 10; i++) begin
            rst = (i == 4 || i == 5);
            if (i == 4) drive(1'b1, 4'hF, 4'd2, 32'hDEAD_BEEF, 1'b1, 4'h0, 4'd14, 32'h0);
            else        drive(1'b1, 4'h0, 4'(i), 32'h0, 1'b1, 4'h0, 4'(15 - i), 32'h0);
        end
        rst = 1'b0;
        drive(1'b1, 4'h0, 4'd2, 32'h0, 1'b1, 4'h0, 4'd3, 32'h0);
        idle(2);

        // Random traffic over a small address window to provoke collisions.
        for (int i = 0; i < 80; i++) begin
            drive(1'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
                  4'(8 + $urandom_range(0, 3)), $urandom,
                  1'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
                  4'(8 + $urandom_range(0, 3)), $urandom);
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
